lu_rr_sequencer: RTL and testbench

- Two-requester round-robin scheduler that shares one registered W-bit logic/compare unit.
- The unit provides NOT, AND, NAND, OR, NOR, XOR, XNOR and magnitude/equality compare.
- Each requester issues op/operand pairs over a valid/ready handshake. The block arbitrates, latches operands, executes, and holds the tagged result until the consumer accepts it.
- It sits between the control units and the shared logic datapath, so at most one operation is in flight at a time.

---
 rtl/lu_rr_sequencer.sv | 147 ++++++++++++++
 tb/tb_lu_rr_sequencer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lu_rr_sequencer.sv
// Two-requester round-robin front end for one shared, registered W-bit logic/compare unit.
// Only one operation is in flight: IDLE accepts, EXEC computes, RESP holds until the consumer takes it.
module lu_rr_sequencer #(
    parameter int W     = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [2:0]       op0,
    input  logic [2:0]       op1,
    input  logic [W-1:0]     a0,
    input  logic [W-1:0]     b0,
    input  logic [W-1:0]     a1,
    input  logic [W-1:0]     b1,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [W-1:0]     result,
    output logic             busy,
    output logic [CNT_W-1:0] done_cnt
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic             resp_valid_q, resp_valid_d;
    logic             resp_id_q, resp_id_d;
    logic [W-1:0]     result_q, result_d;
    logic [CNT_W-1:0] done_cnt_q, done_cnt_d;

    logic [2:0]       op_q, op_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic             id_q, id_d;

    logic             win_id;
    logic [1:0]       grant;
    logic             accept;

    function automatic logic [W-1:0] lu_eval(input logic [2:0] op,
                                             input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        logic [W-1:0] r;
        r = '0;
        case (op)
            3'b000: r = ~a;
            3'b001: r = a & b;
            3'b010: r = ~(a & b);
            3'b011: r = a | b;
            3'b100: r = ~(a | b);
            3'b101: r = a ^ b;
            3'b110: r = ~(a ^ b);
            3'b111: begin
                r[0] = (a == b);
                r[1] = (a > b);
                r[2] = (a < b);
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    // On a tie the requester that did not win last time goes first.
    always_comb begin
        win_id = (req_valid == 2'b11) ? ~last_grant_q : req_valid[1];
        grant  = 2'b00;
        if (state_q == IDLE && req_valid != 2'b00) begin
            grant = win_id ? 2'b10 : 2'b01;
        end
        accept = |grant;
        op_d   = win_id ? op1 : op0;
        a_d    = win_id ? a1  : a0;
        b_d    = win_id ? b1  : b0;
        id_d   = win_id;
    end

    assign req_ready = grant;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        resp_valid_d = resp_valid_q;
        resp_id_d    = resp_id_q;
        result_d     = result_q;
        done_cnt_d   = done_cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d      = EXEC;
                    last_grant_d = win_id;
                end
            end
            EXEC: begin
                result_d     = lu_eval(op_q, a_q, b_q);
                resp_id_d    = id_q;
                resp_valid_d = 1'b1;
                state_d      = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    done_cnt_d   = done_cnt_q + 1'b1;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_id_q    <= 1'b0;
            result_q     <= '0;
            done_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            result_q     <= result_d;
            done_cnt_q   <= done_cnt_d;
        end
    end

    // Operand latch: captured only on acceptance so later requester changes cannot leak in.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q <= op_d;
            a_q  <= a_d;
            b_q  <= b_d;
            id_q <= id_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_id    = resp_id_q;
    assign result     = result_q;
    assign done_cnt   = done_cnt_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_lu_rr_sequencer.sv
// Randomized and directed stimulus for lu_rr_sequencer; a negedge monitor keeps a transaction-level
// model (slot occupancy, round-robin pointer, expected-result queue) and compares every cycle.
module tb_lu_rr_sequencer;

    localparam int W     = 4;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [1:0]       req_valid = 2'b00;
    logic [1:0]       req_ready;
    logic [2:0]       op0 = 3'd0, op1 = 3'd0;
    logic [W-1:0]     a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic             resp_valid;
    logic             resp_ready = 1'b0;
    logic             resp_id;
    logic [W-1:0]     result;
    logic             busy;
    logic [CNT_W-1:0] done_cnt;

    lu_rr_sequencer #(.W(W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .op0(op0), .op1(op1), .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .result(result), .busy(busy), .done_cnt(done_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] res;
        logic         id;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   n_chk = 0;
    int   n_pass = 0;
    int   stim_to = 0;
    bit   end_req = 0;
    bit   end_ack = 0;

    // Reference model state: is the single slot occupied, how long since acceptance,
    // who won last, and how many responses have been taken.
    bit   m_busy = 0;
    int   m_age = 0;
    bit   m_last = 1;
    int   m_cnt = 0;

    function automatic logic [W-1:0] ref_op(input int op, input int a, input int b);
        int m;
        int r;
        m = (1 << W) - 1;
        case (op)
            0: r = m - a;
            1: r = a & b;
            2: r = m - (a & b);
            3: r = a | b;
            4: r = m - (a | b);
            5: r = a ^ b;
            6: r = m - (a ^ b);
            default: r = (a == b) ? 1 : ((a > b) ? 2 : 4);
        endcase
        return W'(r);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    endtask

    initial begin
        logic [1:0] eg;
        exp_t       e;
        forever begin
            @(negedge clk or negedge rst_n);
            #1;
            if (!rst_n) begin
                m_busy = 0; m_age = 0; m_last = 1; m_cnt = 0;
                exp_q.delete();
                chk("rst_resp_valid", 32'(resp_valid), 0);
                chk("rst_busy", 32'(busy), 0);
                chk("rst_done_cnt", 32'(done_cnt), 0);
                chk("rst_result", 32'(result), 0);
                chk("rst_resp_id", 32'(resp_id), 0);
            end else begin
                if (m_busy) eg = 2'b00;
                else if (req_valid == 2'b11) eg = m_last ? 2'b01 : 2'b10;
                else eg = req_valid;
                chk("req_ready", 32'(req_ready), 32'(eg));
                chk("busy", 32'(busy), 32'(m_busy));
                chk("resp_valid", 32'(resp_valid), 32'(m_busy && m_age >= 1));
                if (m_busy && m_age == 1 && exp_q.size() > 0) cur = exp_q.pop_front();
                if (m_busy && m_age >= 1) begin
                    chk("result", 32'(result), 32'(cur.res));
                    chk("resp_id", 32'(resp_id), 32'(cur.id));
                end
                chk("done_cnt", 32'(done_cnt), 32'(m_cnt));
                if (m_busy && m_age >= 1 && resp_ready) begin
                    m_busy = 0;
                    m_cnt = (m_cnt + 1) % (1 << CNT_W);
                end else if (m_busy) begin
                    m_age++;
                end else if (eg != 2'b00) begin
                    e.id  = eg[1];
                    e.res = eg[1] ? ref_op(int'(op1), int'(a1), int'(b1))
                                  : ref_op(int'(op0), int'(a0), int'(b0));
                    exp_q.push_back(e);
                    m_last = eg[1];
                    m_busy = 1;
                    m_age = 0;
                end
                if (end_req && !end_ack && !m_busy) begin
                    chk("queue_empty", 32'(exp_q.size()), 0);
                    end_ack = 1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic set_req(input int id, input int op, input int a, input int b);
        if (id == 0) begin op0 = 3'(op); a0 = W'(a); b0 = W'(b); end
        else begin op1 = 3'(op); a1 = W'(a); b1 = W'(b); end
    endtask

    task automatic issue(input int id, input int op, input int a, input int b);
        bit got;
        got = 0;
        set_req(id, op, a, b);
        req_valid[id] = 1'b1;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            if (req_ready[id]) got = 1;
        end
        if (!got) begin
            stim_to++;
            $display("FAIL issue_timeout: requester %0d not accepted within 30 cycles", id);
        end
        @(posedge clk);
        #1;
        req_valid[id] = 1'b0;
        set_req(id, $urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 15));
    endtask

    task automatic wait_idle();
        bit idle;
        idle = 0;
        for (int i = 0; i < 50 && !idle; i++) begin
            @(negedge clk);
            if (!busy) idle = 1;
        end
        if (!idle) begin
            stim_to++;
            $display("FAIL idle_timeout: busy stuck high for 50 cycles");
        end
        tick();
    endtask

    task automatic rand_ops();
        set_req(0, $urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 15));
        set_req(1, $urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 15));
    endtask

    initial begin
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (2) tick();

        pulse_reset();
        tick();
        resp_ready = 1'b1;
        issue(0, 1, 4'b1100, 4'b1010);
        wait_idle();

        for (int op = 0; op < 8; op++) begin
            issue(1, op, 4'b0110, 4'b0011);
            wait_idle();
        end
        issue(1, 7, 4'b0101, 4'b0101);
        wait_idle();
        issue(1, 7, 2, 9);
        wait_idle();

        pulse_reset();
        resp_ready = 1'b1;
        req_valid = 2'b11;
        for (int i = 0; i < 12; i++) begin
            rand_ops();
            tick();
        end
        req_valid = 2'b00;
        wait_idle();

        resp_ready = 1'b0;
        issue(0, $urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 15));
        repeat (7) tick();
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        repeat (2) tick();
        resp_ready = 1'b1;

        issue(0, 5, 4'b1001, 4'b0110);
        req_valid[1] = 1'b1;
        issue(1, 3, 4'b0001, 4'b1000);
        wait_idle();

        pulse_reset();
        resp_ready = 1'b1;
        req_valid = 2'b11;
        for (int i = 0; i < 256 * 3 + 4; i++) begin
            rand_ops();
            tick();
        end
        req_valid = 2'b00;
        wait_idle();

        resp_ready = 1'b0;
        issue(1, $urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 15));
        repeat (3) tick();
        pulse_reset();
        resp_ready = 1'b1;
        req_valid = 2'b11;
        repeat (4) tick();
        req_valid = 2'b00;
        wait_idle();

        for (int i = 0; i < 1500; i++) begin
            req_valid = 2'($urandom_range(0, 3));
            resp_ready = ($urandom_range(0, 3) != 0);
            rand_ops();
            tick();
        end
        req_valid = 2'b00;
        resp_ready = 1'b1;
        wait_idle();

        end_req = 1;
        for (int i = 0; i < 20 && !end_ack; i++) tick();
        if (!end_ack) begin
            stim_to++;
            $display("FAIL end_timeout: monitor did not reach final drain check");
        end
        $display("%0d/%0d checks passed", n_pass, n_chk + stim_to);
        $finish;
    end

endmodule
